// File: rtl/noc_flit_rx_axis_if.sv
// rtl/noc_flit_rx_axis_if.sv - AXI-Stream beat interface for the flit receiver output
//
// Purpose: groups the reassembled-beat stream signals into one bundle.
// Signals:
//   tvalid  beat valid (driven by master)
//   tready  beat accepted (driven by slave)
//   tdata   beat payload
//   tlast   packet end
//   tid     stream id
//   tdest   stream destination
interface noc_flit_rx_axis_if #(
    parameter int TDATA_WIDTH = 128,
    parameter int TDEST_WIDTH = 4,
    parameter int TID_WIDTH   = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/noc_flit_rx_axis.sv
// rtl/noc_flit_rx_axis.sv - NoC ejection endpoint: flit FIFO, credit return, AXIS beat reassembly
//
// Purpose: buffers incoming flits, returns one credit per dequeued flit and
// packs SERIALIZATION_FACTOR flits (first flit in the LSBs) into one AXIS beat.
// Ports:
//   clk_noc       sole clock
//   rst_n         asynchronous active-low reset
//   data_in       flit payload
//   dest_in       flit destination {tid, tdest}
//   is_tail_in    last flit of packet
//   send_in       flit valid
//   credit_out    one-cycle pulse per freed FIFO slot
//   axis_out      registered AXIS master beat output
//   overflow_err  sticky: flit arrived while FIFO full
//   protocol_err  sticky: tail seen on a non-final flit slot
module noc_flit_rx_axis #(
    parameter int TDATA_WIDTH          = 128,
    parameter int TDEST_WIDTH          = 4,
    parameter int TID_WIDTH            = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    noc_flit_rx_axis_if.master    axis_out,
    output logic                  overflow_err,
    output logic                  protocol_err
);
    localparam int AW = $clog2(FLIT_BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SERIALIZATION_FACTOR - 1);

    logic [FLIT_WIDTH-1:0]  r_fifo_data [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0]  r_fifo_dest [FLIT_BUFFER_DEPTH];
    logic                   r_fifo_tail [FLIT_BUFFER_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [IW-1:0]          r_idx;
    logic [TDATA_WIDTH-1:0] r_asm;
    logic                   r_credit;
    logic                   r_tvalid;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tlast;
    logic [TID_WIDTH-1:0]   r_tid;
    logic [TDEST_WIDTH-1:0] r_tdest;
    logic                   r_overflow_err;
    logic                   r_protocol_err;

    logic                   w_empty;
    logic                   w_full;
    logic [FLIT_WIDTH-1:0]  w_head_data;
    logic [DEST_WIDTH-1:0]  w_head_dest;
    logic                   w_head_tail;
    logic                   w_final;
    logic                   w_out_free;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [TDATA_WIDTH-1:0] w_beat;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_head_data = r_fifo_data[r_rd_ptr[AW-1:0]];
    assign w_head_dest = r_fifo_dest[r_rd_ptr[AW-1:0]];
    assign w_head_tail = r_fifo_tail[r_rd_ptr[AW-1:0]];

    // A tail closes the beat early, so it is treated like the last slot.
    assign w_final    = (r_idx == LAST_IDX) || w_head_tail;
    assign w_out_free = !r_tvalid || axis_out.tready;
    assign w_pop      = !w_empty && (!w_final || w_out_free);
    // A pop in the same cycle frees the slot, so a write on a full FIFO is kept.
    assign w_push     = send_in && (!w_full || w_pop);
    assign w_drop     = send_in && w_full && !w_pop;

    // Unfilled upper slices stay zero because the assembly register is cleared per beat.
    always_comb begin
        w_beat = r_asm;
        w_beat[int'(r_idx) * FLIT_WIDTH +: FLIT_WIDTH] = w_head_data;
    end

    // Storage needs no reset: occupancy is defined entirely by the pointers.
    always_ff @(posedge clk_noc) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr[AW-1:0]] <= data_in;
            r_fifo_dest[r_wr_ptr[AW-1:0]] <= dest_in;
            r_fifo_tail[r_wr_ptr[AW-1:0]] <= is_tail_in;
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_idx          <= '0;
            r_asm          <= '0;
            r_credit       <= 1'b0;
            r_tvalid       <= 1'b0;
            r_tdata        <= '0;
            r_tlast        <= 1'b0;
            r_tid          <= '0;
            r_tdest        <= '0;
            r_overflow_err <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_credit <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            if (w_pop && w_head_tail && (r_idx != LAST_IDX)) begin
                r_protocol_err <= 1'b1;
            end

            if (w_pop && !w_final) begin
                r_asm <= w_beat;
                r_idx <= r_idx + 1'b1;
            end

            // Reload takes priority over drain so back-to-back beats need no bubble.
            if (w_pop && w_final) begin
                r_tvalid         <= 1'b1;
                r_tdata          <= w_beat;
                r_tlast          <= w_head_tail;
                {r_tid, r_tdest} <= w_head_dest;
                r_idx            <= '0;
                r_asm            <= '0;
            end else if (axis_out.tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign credit_out      = r_credit;
    assign overflow_err    = r_overflow_err;
    assign protocol_err    = r_protocol_err;
    assign axis_out.tvalid = r_tvalid;
    assign axis_out.tdata  = r_tdata;
    assign axis_out.tlast  = r_tlast;
    assign axis_out.tid    = r_tid;
    assign axis_out.tdest  = r_tdest;
endmodule

// File: tb/tb_noc_flit_rx_axis.sv
// tb/tb_noc_flit_rx_axis.sv - testbench for noc_flit_rx_axis
module tb_noc_flit_rx_axis;
    localparam int TW    = 128;
    localparam int DW    = 4;
    localparam int IDW   = 2;
    localparam int SF    = 2;
    localparam int FW    = TW / SF;
    localparam int DSTW  = DW + IDW;
    localparam int DEPTH = 4;

    logic clk_noc = 1'b0;
    logic rst_n;
    always #5 clk_noc = ~clk_noc;

    logic [FW-1:0]   data_in;
    logic [DSTW-1:0] dest_in;
    logic            is_tail_in;
    logic            send_in;
    logic            credit_out;
    logic            overflow_err;
    logic            protocol_err;
    noc_flit_rx_axis_if #(.TDATA_WIDTH(TW), .TDEST_WIDTH(DW), .TID_WIDTH(IDW)) axis_if ();

    noc_flit_rx_axis #(
        .TDATA_WIDTH(TW), .TDEST_WIDTH(DW), .TID_WIDTH(IDW),
        .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
    ) u_dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
        .axis_out(axis_if), .overflow_err(overflow_err), .protocol_err(protocol_err)
    );

    logic [TW-1:0]   d1_data;
    logic [DSTW-1:0] d1_dest;
    logic            d1_tail;
    logic            d1_send;
    logic            d1_credit;
    logic            d1_ovf;
    logic            d1_perr;
    noc_flit_rx_axis_if #(.TDATA_WIDTH(TW), .TDEST_WIDTH(DW), .TID_WIDTH(IDW)) axis1_if ();

    noc_flit_rx_axis #(
        .TDATA_WIDTH(TW), .TDEST_WIDTH(DW), .TID_WIDTH(IDW),
        .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(DEPTH)
    ) u_dut1 (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(d1_data), .dest_in(d1_dest),
        .is_tail_in(d1_tail), .send_in(d1_send), .credit_out(d1_credit),
        .axis_out(axis1_if), .overflow_err(d1_ovf), .protocol_err(d1_perr)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [134:0] cur_beat();
        return {axis_if.tdata, axis_if.tlast, axis_if.tid, axis_if.tdest};
    endfunction

    task automatic send_flit(input logic [FW-1:0] d, input logic [DSTW-1:0] de, input logic t);
        data_in    = d;
        dest_in    = de;
        is_tail_in = t;
        send_in    = 1'b1;
    endtask

    task automatic idle();
        send_in    = 1'b0;
        is_tail_in = 1'b0;
        data_in    = '0;
        dest_in    = '0;
    endtask

    task automatic cyc();
        @(negedge clk_noc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: flits accepted in order, grouped into beats by the slot/tail rules.
    logic [134:0] exp_q[$];
    logic [134:0] got_q[$];
    logic [TW-1:0] m_acc;
    int  m_k;
    bit  m_early;

    task automatic model_flit(input logic [FW-1:0] d, input logic [DSTW-1:0] de, input logic t);
        m_acc[m_k*FW +: FW] = d;
        if (m_k == SF - 1 || t) begin
            if (m_k != SF - 1) m_early = 1'b1;
            exp_q.push_back({m_acc, t, de});
            m_acc = '0;
            m_k   = 0;
        end else begin
            m_k++;
        end
    endtask

    logic [FW-1:0]  of_d [9];
    logic [TW-1:0]  s1d  [16];
    logic           s1t  [16];
    logic [134:0]   prev_beat;
    logic [FW-1:0]  rd;
    logic [DSTW-1:0] rde;
    logic           rt;
    bit             prev_stall;
    bit             exp_v;
    int             credits;
    int             cred_cnt;
    int             n_sent;

    initial begin
        rst_n = 1'b0;
        idle();
        d1_send = 1'b0; d1_data = '0; d1_dest = '0; d1_tail = 1'b0;
        axis_if.tready  = 1'b0;
        axis1_if.tready = 1'b0;
        cyc();
        cyc();
        chk("reset_state", {axis_if.tvalid, credit_out, overflow_err, protocol_err, cur_beat()}, '0);
        chk("reset_state_sf1", {axis1_if.tvalid, d1_credit, d1_ovf, d1_perr, axis1_if.tdata}, '0);
        rst_n = 1'b1;

        // Two-flit packet, LSB flit first, dest taken from final flit.
        axis_if.tready = 1'b1;
        send_flit({16{4'hA}}, 6'b01_0011, 1'b0);
        cyc();
        chk("t1_n1_credit", credit_out, 0);
        send_flit({16{4'hB}}, 6'b10_0101, 1'b1);
        cyc();
        chk("t1_n2_credit", credit_out, 1);
        chk("t1_n2_tvalid", axis_if.tvalid, 0);
        idle();
        cyc();
        chk("t1_n3_tvalid", axis_if.tvalid, 1);
        chk("t1_n3_beat", cur_beat(), {{16{4'hB}}, {16{4'hA}}, 1'b1, 2'd2, 4'd5});
        chk("t1_n3_credit", credit_out, 1);
        cyc();
        chk("t1_n4_idle", {axis_if.tvalid, credit_out}, 0);

        // Early tail on slot 0.
        chk("t2_perr_before", protocol_err, 0);
        send_flit(64'h1234, 6'b01_0110, 1'b1);
        cyc();
        idle();
        chk("t2_n1_perr", protocol_err, 0);
        cyc();
        chk("t2_n2_beat", {axis_if.tvalid, cur_beat()}, {1'b1, 128'h1234, 1'b1, 2'd1, 4'd6});
        chk("t2_n2_perr", protocol_err, 1);
        cyc();
        chk("t2_n3_state", {axis_if.tvalid, protocol_err}, 2'b01);

        // Asynchronous reset with a beat pending and a half-built packet.
        axis_if.tready = 1'b0;
        send_flit({8{8'h11}}, 6'd1, 1'b0);
        cyc();
        send_flit({8{8'h22}}, 6'd2, 1'b1);
        cyc();
        send_flit({8{8'h33}}, 6'd3, 1'b0);
        cyc();
        idle();
        cyc();
        chk("t3_pre_reset", {axis_if.tvalid, credit_out, protocol_err}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t3_async_reset", {axis_if.tvalid, credit_out, overflow_err, protocol_err}, 0);
        cyc();
        rst_n = 1'b1;
        axis_if.tready = 1'b1;
        send_flit({8{8'hCC}}, 6'b00_0001, 1'b0);
        cyc();
        send_flit({8{8'hDD}}, 6'b11_1010, 1'b1);
        cyc();
        idle();
        cyc();
        chk("t3_fresh_beat", {axis_if.tvalid, cur_beat()}, {1'b1, {8{8'hDD}}, {8{8'hCC}}, 1'b1, 2'd3, 4'd10});
        cyc();

        // Overflow: eight back-to-back flits with output stalled, eighth dropped.
        axis_if.tready = 1'b0;
        cred_cnt = 0;
        got_q.delete();
        for (int i = 0; i < 9; i++) of_d[i] = {$urandom, $urandom};
        for (int k = 0; k < 30; k++) begin
            if (k == 8) axis_if.tready = 1'b1;
            if (credit_out) cred_cnt++;
            if (axis_if.tvalid && axis_if.tready) got_q.push_back(cur_beat());
            if (k == 7) chk("t4_ovf_before_drop", overflow_err, 0);
            if (k == 8) chk("t4_ovf_after_drop", overflow_err, 1);
            if (k < 8) send_flit(of_d[k], 6'(k), 1'b0);
            else if (k == 8) send_flit(of_d[8], 6'd8, 1'b1);
            else idle();
            cyc();
        end
        chk("t4_beat_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("t4_beat0", got_q[0], {of_d[1], of_d[0], 1'b0, 6'd1});
            chk("t4_beat1", got_q[1], {of_d[3], of_d[2], 1'b0, 6'd3});
            chk("t4_beat2", got_q[2], {of_d[5], of_d[4], 1'b0, 6'd5});
            chk("t4_beat3", got_q[3], {of_d[8], of_d[6], 1'b1, 6'd8});
        end
        chk("t4_credits", cred_cnt, 8);
        chk("t4_flags", {overflow_err, protocol_err}, 2'b10);

        // Randomized traffic under credit flow control against the grouping model.
        do_reset();
        exp_q.delete();
        m_acc = '0; m_k = 0; m_early = 1'b0;
        credits = DEPTH; cred_cnt = 0; n_sent = 0; prev_stall = 1'b0; prev_beat = '0;
        for (int c = 0; c < 2000; c++) begin
            if (credit_out) begin
                credits++;
                cred_cnt++;
            end
            if (prev_stall) chk("rnd_hold", {axis_if.tvalid, cur_beat()}, {1'b1, prev_beat});
            axis_if.tready = ($urandom_range(0, 3) != 0);
            if (axis_if.tvalid && axis_if.tready) begin
                chk("rnd_beat_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("rnd_beat", cur_beat(), exp_q.pop_front());
            end
            prev_stall = axis_if.tvalid && !axis_if.tready;
            prev_beat  = cur_beat();
            if (c >= 600 && m_k == 0 && exp_q.size() == 0 && credits == DEPTH) begin
                idle();
                break;
            end
            if ((c < 600 || m_k != 0) && credits > 0 && $urandom_range(0, 2) != 0) begin
                rd  = {$urandom, $urandom};
                rde = DSTW'($urandom);
                rt  = ($urandom_range(0, 3) == 0);
                send_flit(rd, rde, rt);
                model_flit(rd, rde, rt);
                credits--;
                n_sent++;
            end else begin
                idle();
            end
            cyc();
        end
        chk("rnd_all_beats_seen", exp_q.size(), 0);
        chk("rnd_credit_total", cred_cnt, n_sent);
        chk("rnd_credits_home", credits, DEPTH);
        chk("rnd_no_overflow", overflow_err, 0);
        chk("rnd_protocol_err", protocol_err, m_early);
        axis_if.tready = 1'b0;
        cyc();

        // SF=1: one beat per cycle under continuous traffic.
        axis1_if.tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_v = (k >= 2 && k <= 17);
            chk("sf1_tvalid", axis1_if.tvalid, exp_v);
            chk("sf1_credit", d1_credit, exp_v);
            if (exp_v) chk("sf1_beat", {axis1_if.tdata, axis1_if.tlast, axis1_if.tid, axis1_if.tdest},
                           {s1d[k-2], s1t[k-2], 6'(k - 2)});
            if (k < 16) begin
                s1d[k]  = {$urandom, $urandom, $urandom, $urandom};
                s1t[k]  = 1'($urandom_range(0, 1));
                d1_data = s1d[k];
                d1_dest = 6'(k);
                d1_tail = s1t[k];
                d1_send = 1'b1;
            end else begin
                d1_send = 1'b0;
                d1_tail = 1'b0;
            end
            cyc();
        end
        chk("sf1_flags", {d1_ovf, d1_perr}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
